ahb_config_slave: RTL

Parametrised AHB-Lite slave that holds the edge-detector job configuration: image dimensions, source and destination addresses, and filter mode. It exposes that configuration to the datapath controllers and sequences start, abort and done through a control/status register pair. It replaces fixed-order, read-once configuration capture with random-access, read-back-capable registers, proper HREADYOUT/HRESP signalling and a repeatable job lifecycle.

---
 rtl/ahb_cfg_pkg.sv | 53 +++++
 rtl/ahb_config_slave_if.sv | 101 ++++++++++
 rtl/ahb_config_slave.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_cfg_pkg.sv
// Shared constants and state types for the edge-detector configuration slave.
package ahb_cfg_pkg;

    localparam int unsigned OFF_BITS = 3;

    // Register word offsets from the window base
    localparam logic [OFF_BITS-1:0] OFF_WIDTH   = 3'd0;
    localparam logic [OFF_BITS-1:0] OFF_HEIGHT  = 3'd1;
    localparam logic [OFF_BITS-1:0] OFF_RD_ADDR = 3'd2;
    localparam logic [OFF_BITS-1:0] OFF_WR_ADDR = 3'd3;
    localparam logic [OFF_BITS-1:0] OFF_FILTER  = 3'd4;
    localparam logic [OFF_BITS-1:0] OFF_CTRL    = 3'd5;
    localparam logic [OFF_BITS-1:0] OFF_STATUS  = 3'd6;
    localparam logic [OFF_BITS-1:0] OFF_ID      = 3'd7;

    // CTRL bit positions
    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;
    localparam int unsigned CTRL_ABORT_BIT  = 2;

    // STATUS bit positions
    localparam int unsigned STATUS_BUSY_BIT    = 0;
    localparam int unsigned STATUS_DONE_BIT    = 1;
    localparam int unsigned STATUS_CFG_ERR_BIT = 2;
    localparam int unsigned STATUS_OVERRUN_BIT = 3;

    // AHB encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        RESP_ADDR,
        RESP_DATA,
        RESP_ERR1,
        RESP_ERR2
    } resp_state_t;

    typedef enum logic {
        JOB_IDLE,
        JOB_RUN
    } job_state_t;

    // Offsets holding job configuration that must stay frozen while a job runs
    function automatic logic is_cfg_offset(input logic [OFF_BITS-1:0] off);
        return off <= OFF_FILTER;
    endfunction

endpackage

// File: rtl/ahb_config_slave_if.sv
// AHB-Lite address-phase capture, response sequencing and error detection.
module ahb_slave_if
    import ahb_cfg_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_0D00)
) (
    input  logic                  ahb_hclk,
    input  logic                  rst,
    input  logic                  ahb_hsel,
    input  logic [ADDR_WIDTH-1:0] ahb_haddr,
    input  logic [1:0]            ahb_htrans,
    input  logic                  ahb_hwrite,
    input  logic [2:0]            ahb_hsize,
    input  logic                  ahb_hready,
    input  logic                  busy,
    output logic                  ahb_hreadyout,
    output logic                  ahb_hresp,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [OFF_BITS-1:0]   offset
);

    logic [ADDR_WIDTH-1:0] addr_rel;
    logic [OFF_BITS-1:0]   addr_off;
    logic                  unused_addr;
    logic                  xfer_valid;
    logic                  accept;
    logic                  req_err;
    resp_state_t           state_q;
    resp_state_t           state_d;
    logic                  wr_q;
    logic                  rd_q;
    logic [OFF_BITS-1:0]   off_q;

    // Word offset inside the 32-byte window; the select decoder owns the upper bits
    assign addr_rel    = ahb_haddr - BASE_ADDR;
    assign addr_off    = addr_rel[OFF_BITS+1:2];
    assign unused_addr = ^{addr_rel[ADDR_WIDTH-1:OFF_BITS+2], addr_rel[1:0]};

    // Only NONSEQ/SEQ carry a real transfer
    always_comb begin
        xfer_valid = 1'b0;
        case (ahb_htrans)
            HTRANS_IDLE, HTRANS_BUSY:  xfer_valid = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: xfer_valid = 1'b1;
            default:                   xfer_valid = 1'b0;
        endcase
    end

    assign accept  = ahb_hsel && xfer_valid && ahb_hready && (state_q != RESP_ERR1);
    assign req_err = (ahb_hsize != HSIZE_WORD)
                   || (ahb_hwrite && (addr_off == OFF_ID))
                   || (ahb_hwrite && is_cfg_offset(addr_off) && busy);

    // Response state register
    always_ff @(posedge ahb_hclk) begin
        if (rst) begin
            state_q <= RESP_ADDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Response next state; ERR1 always stretches into ERR2 before a new transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESP_ERR1: state_d = RESP_ERR2;
            default: begin
                if (accept) begin
                    state_d = req_err ? RESP_ERR1 : RESP_DATA;
                end else begin
                    state_d = RESP_ADDR;
                end
            end
        endcase
    end

    // Address-phase register: errored transfers never reach the register file
    always_ff @(posedge ahb_hclk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            off_q <= '0;
        end else begin
            wr_q <= accept && !req_err && ahb_hwrite;
            rd_q <= accept && !req_err && !ahb_hwrite;
            if (accept) begin
                off_q <= addr_off;
            end
        end
    end

    assign wr_en         = wr_q;
    assign rd_en         = rd_q;
    assign offset        = off_q;
    assign ahb_hreadyout = (state_q != RESP_ERR1);
    assign ahb_hresp     = ((state_q == RESP_ERR1) || (state_q == RESP_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_config_slave.sv
// Edge-detector job configuration registers with start/abort/done sequencing.
module ahb_config_slave
    import ahb_cfg_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0000_0D00),
    parameter int unsigned           DIM_BITS    = 16,
    parameter int unsigned           FILTER_BITS = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'h0ED6_0002)
) (
    input  logic                   ahb_hclk,
    input  logic                   rst,
    input  logic                   ahb_hsel,
    input  logic [ADDR_WIDTH-1:0]  ahb_haddr,
    input  logic [1:0]             ahb_htrans,
    input  logic                   ahb_hwrite,
    input  logic [2:0]             ahb_hsize,
    input  logic [DATA_WIDTH-1:0]  ahb_hwdata,
    input  logic                   ahb_hready,
    output logic                   ahb_hreadyout,
    output logic                   ahb_hresp,
    output logic [DATA_WIDTH-1:0]  ahb_hrdata,
    output logic [DIM_BITS-1:0]    width,
    output logic [DIM_BITS-1:0]    height,
    output logic [DATA_WIDTH-1:0]  read_start_address,
    output logic [DATA_WIDTH-1:0]  write_start_address,
    output logic [FILTER_BITS-1:0] filter_type,
    output logic                   start,
    output logic                   abort,
    input  logic                   core_done,
    output logic                   irq
);

    logic                   wr_en;
    logic                   rd_en;
    logic [OFF_BITS-1:0]    offset;
    job_state_t             job_q;
    job_state_t             job_d;
    logic [DIM_BITS-1:0]    width_q;
    logic [DIM_BITS-1:0]    height_q;
    logic [DATA_WIDTH-1:0]  rd_addr_q;
    logic [DATA_WIDTH-1:0]  wr_addr_q;
    logic [FILTER_BITS-1:0] filter_q;
    logic                   irq_en_q, irq_en_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   overrun_q, overrun_d;
    logic                   start_q, abort_q, irq_q;
    logic                   busy, busy_eff, dims_ok;
    logic                   ctrl_wr, status_wr;
    logic                   start_req, abort_req, start_go, abort_go, done_evt;
    logic [DATA_WIDTH-1:0]  rd_mux;

    ahb_slave_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_if (
        .ahb_hclk      (ahb_hclk),
        .rst           (rst),
        .ahb_hsel      (ahb_hsel),
        .ahb_haddr     (ahb_haddr),
        .ahb_htrans    (ahb_htrans),
        .ahb_hwrite    (ahb_hwrite),
        .ahb_hsize     (ahb_hsize),
        .ahb_hready    (ahb_hready),
        .busy          (busy),
        .ahb_hreadyout (ahb_hreadyout),
        .ahb_hresp     (ahb_hresp),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .offset        (offset)
    );

    // core_done is handled before a same-cycle START, so START sees the job as finished
    assign busy      = (job_q == JOB_RUN);
    assign done_evt  = core_done && busy;
    assign busy_eff  = busy && !core_done;
    assign dims_ok   = (width_q != '0) && (height_q != '0);
    assign ctrl_wr   = wr_en && (offset == OFF_CTRL);
    assign status_wr = wr_en && (offset == OFF_STATUS);
    assign start_req = ctrl_wr && ahb_hwdata[CTRL_START_BIT];
    assign abort_req = ctrl_wr && ahb_hwdata[CTRL_ABORT_BIT];
    assign start_go  = start_req && !busy_eff && dims_ok;
    assign abort_go  = abort_req && busy_eff;

    // Job state register and lifecycle flags
    always_ff @(posedge ahb_hclk) begin
        if (rst) begin
            job_q     <= JOB_IDLE;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            overrun_q <= 1'b0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            job_q     <= job_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            overrun_q <= overrun_d;
            start_q   <= start_go;
            abort_q   <= abort_go;
            irq_q     <= irq_en_d && done_d;
        end
    end

    // Job next state
    always_comb begin
        job_d = job_q;
        case (job_q)
            JOB_IDLE: begin
                if (start_go) begin
                    job_d = JOB_RUN;
                end
            end
            JOB_RUN: begin
                if (start_go) begin
                    job_d = JOB_RUN;
                end else if (core_done || abort_go) begin
                    job_d = JOB_IDLE;
                end
            end
            default: job_d = JOB_IDLE;
        endcase
    end

    // Sticky status next values; hardware set wins over a same-cycle W1C
    always_comb begin
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        cfg_err_d = cfg_err_q;
        overrun_d = overrun_q;
        if (ctrl_wr) begin
            irq_en_d = ahb_hwdata[CTRL_IRQ_EN_BIT];
        end
        if (status_wr && ahb_hwdata[STATUS_DONE_BIT]) begin
            done_d = 1'b0;
        end
        if (done_evt) begin
            done_d = 1'b1;
        end
        if (start_go) begin
            done_d = 1'b0;
        end
        if (status_wr && ahb_hwdata[STATUS_CFG_ERR_BIT]) begin
            cfg_err_d = 1'b0;
        end
        if (start_req && !busy_eff && !dims_ok) begin
            cfg_err_d = 1'b1;
        end
        if (status_wr && ahb_hwdata[STATUS_OVERRUN_BIT]) begin
            overrun_d = 1'b0;
        end
        if (start_req && busy_eff) begin
            overrun_d = 1'b1;
        end
    end

    // Configuration registers, written at the end of an accepted data phase
    always_ff @(posedge ahb_hclk) begin
        if (rst) begin
            width_q   <= '0;
            height_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            filter_q  <= '0;
        end else if (wr_en) begin
            case (offset)
                OFF_WIDTH:   width_q   <= ahb_hwdata[DIM_BITS-1:0];
                OFF_HEIGHT:  height_q  <= ahb_hwdata[DIM_BITS-1:0];
                OFF_RD_ADDR: rd_addr_q <= ahb_hwdata;
                OFF_WR_ADDR: wr_addr_q <= ahb_hwdata;
                OFF_FILTER:  filter_q  <= ahb_hwdata[FILTER_BITS-1:0];
                default: ;
            endcase
        end
    end

    // Read-back mux from registered state; pulse bits always read 0
    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_WIDTH:   rd_mux = DATA_WIDTH'(width_q);
            OFF_HEIGHT:  rd_mux = DATA_WIDTH'(height_q);
            OFF_RD_ADDR: rd_mux = rd_addr_q;
            OFF_WR_ADDR: rd_mux = wr_addr_q;
            OFF_FILTER:  rd_mux = DATA_WIDTH'(filter_q);
            OFF_CTRL:    rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
            OFF_STATUS: begin
                rd_mux[STATUS_BUSY_BIT]    = busy;
                rd_mux[STATUS_DONE_BIT]    = done_q;
                rd_mux[STATUS_CFG_ERR_BIT] = cfg_err_q;
                rd_mux[STATUS_OVERRUN_BIT] = overrun_q;
            end
            OFF_ID:      rd_mux = ID_VALUE;
            default: ;
        endcase
    end

    assign ahb_hrdata          = rd_en ? rd_mux : '0;
    assign width               = width_q;
    assign height              = height_q;
    assign read_start_address  = rd_addr_q;
    assign write_start_address = wr_addr_q;
    assign filter_type         = filter_q;
    assign start               = start_q;
    assign abort               = abort_q;
    assign irq                 = irq_q;

endmodule
